// File: rtl/sdram_seq_pkg.sv
// Shared state encoding and constants for the SDRAM FIFO test sequencer.
package sdram_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FILL,
      ST_READ,
      ST_CHECK,
      ST_DONE
   } seq_state_t;

   localparam int CSUM_W      = 32;
   localparam int LOAD_CYCLES = 2;
   localparam int LOAD_CNT_W  = 2;

endpackage

// File: rtl/sdram_seq_timeout.sv
// Read-side watchdog: loadable down-counter with clear, decrement enable and terminal count.
module sdram_seq_timeout #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/sdram_test_seq.sv
// Test sequencer for the SDRAM controller FIFO user ports: load, fill, drain and grade one pass.
// Define SDRAM_SEQ_ROM_EN to source write data from an external pattern ROM (checksum-only grading).
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | wr_load/rd_load held high for LOAD_CYCLES cycles
// FILL  | streaming NUM_WORDS words into the write FIFO
// READ  | draining NUM_WORDS words with the watchdog armed
// CHECK | single cycle forming the pass decision
// DONE  | results held until the next start
module sdram_test_seq
   import sdram_seq_pkg::*;
#(
   parameter int          DSIZE        = 16,
   parameter int          NUM_WORDS    = 16,
   parameter logic [15:0] PATTERN_SEED = 16'hA5A5,
   parameter int          TIMEOUT      = 4096
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   output logic [15:0]      rom_addr,
   input  logic [DSIZE-1:0] rom_q,
   output logic [DSIZE-1:0] wr_data,
   output logic             wr_en,
   input  logic             wr_full,
   output logic             wr_load,
   output logic             rd_load,
   output logic             rd_en,
   input  logic [DSIZE-1:0] rd_data,
   input  logic             rd_empty,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [15:0]      err_count,
   output logic [DSIZE-1:0] last_rd_data
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [15:0]      LAST_IDX = 16'(NUM_WORDS - 1);
   localparam logic [15:0]      WORD_CNT = 16'(NUM_WORDS);
   localparam logic [DSIZE-1:0] SEED     = DSIZE'(PATTERN_SEED);

   seq_state_t            state_q, state_d;
   logic [LOAD_CNT_W-1:0] load_cnt_q, load_cnt_d;
   logic [15:0]           wr_idx_q, wr_idx_d;
   logic [15:0]           rd_idx_q, rd_idx_d;
   logic [CSUM_W-1:0]     wsum_q, wsum_d;
   logic [CSUM_W-1:0]     rsum_q, rsum_d;
   logic [15:0]           err_count_q, err_count_d;
   logic [DSIZE-1:0]      last_rd_data_q, last_rd_data_d;
   logic                  pass_q, pass_d;
   logic                  timeout_q, timeout_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  load_q, load_d;

   logic                  rom_vld;
   logic [DSIZE-1:0]      wr_word;
   logic                  to_clr, to_load, to_dec, to_tc;

`ifdef SDRAM_SEQ_ROM_EN
   logic [15:0] rom_addr_q, rom_addr_d;
   logic        rom_vld_q, rom_vld_d;

   assign rom_vld  = rom_vld_q;
   assign wr_word  = (state_q == ST_FILL) ? rom_q : '0;
   assign rom_addr = rom_addr_q;
`else
   logic [DSIZE-1:0] wr_data_q, wr_data_d;
   logic             unused_rom;

   // Pattern is computed from the index, so a word is ready every FILL cycle.
   assign rom_vld    = (state_q == ST_FILL);
   assign wr_word    = wr_data_q;
   assign rom_addr   = '0;
   assign unused_rom = ^rom_q;
`endif

   assign wr_en  = (state_q == ST_FILL) & rom_vld & ~wr_full;
   // A terminal count suppresses a read that would coincide with it.
   assign rd_en  = (state_q == ST_READ) & ~rd_empty & (rd_idx_q < WORD_CNT) & ~rd_pend_q & ~to_tc;
   assign to_dec = (state_q == ST_READ) & ~rd_en & ~rd_pend_q;

   always_comb begin
      state_d        = state_q;
      load_cnt_d     = load_cnt_q;
      wr_idx_d       = wr_idx_q;
      rd_idx_d       = rd_idx_q;
      wsum_d         = wsum_q;
      rsum_d         = rsum_q;
      err_count_d    = err_count_q;
      last_rd_data_d = last_rd_data_q;
      pass_d         = pass_q;
      timeout_d      = timeout_q;
      rd_pend_d      = rd_en;
      to_clr         = 1'b0;
      to_load        = rd_en;
`ifdef SDRAM_SEQ_ROM_EN
      rom_addr_d     = rom_addr_q;
      rom_vld_d      = rom_vld_q;
`else
      wr_data_d      = wr_data_q;
`endif

      if (rd_pend_q) begin
         last_rd_data_d = rd_data;
         rsum_d         = rsum_q + CSUM_W'(rd_data);
         rd_idx_d       = rd_idx_q + 16'd1;
`ifndef SDRAM_SEQ_ROM_EN
         if ((rd_data != (DSIZE'(rd_idx_q) ^ SEED)) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
         end
`endif
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d        = ST_LOAD;
               load_cnt_d     = '0;
               wr_idx_d       = '0;
               rd_idx_d       = '0;
               wsum_d         = '0;
               rsum_d         = '0;
               err_count_d    = '0;
               last_rd_data_d = '0;
               pass_d         = 1'b0;
               timeout_d      = 1'b0;
               to_clr         = 1'b1;
`ifdef SDRAM_SEQ_ROM_EN
               rom_addr_d     = '0;
               rom_vld_d      = 1'b0;
`else
               wr_data_d      = SEED;
`endif
            end
         end
         ST_LOAD: begin
            if (load_cnt_q == LOAD_CNT_W'(LOAD_CYCLES - 1)) begin
               state_d = ST_FILL;
            end else begin
               load_cnt_d = load_cnt_q + 1'b1;
            end
         end
         ST_FILL: begin
            if (wr_en) begin
               wr_idx_d = wr_idx_q + 16'd1;
               wsum_d   = wsum_q + CSUM_W'(wr_word);
`ifdef SDRAM_SEQ_ROM_EN
               rom_addr_d = wr_idx_q + 16'd1;
               rom_vld_d  = 1'b0;
`else
               wr_data_d  = DSIZE'(wr_idx_q + 16'd1) ^ SEED;
`endif
               if (wr_idx_q == LAST_IDX) begin
                  state_d = ST_READ;
                  to_load = 1'b1;
               end
            end else begin
`ifdef SDRAM_SEQ_ROM_EN
               rom_vld_d = 1'b1;
`endif
            end
         end
         ST_READ: begin
            if (to_tc) begin
               timeout_d = 1'b1;
               state_d   = ST_CHECK;
            end else if (rd_idx_q == WORD_CNT) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            pass_d  = ~timeout_q & (wsum_q == rsum_q) & (err_count_q == 16'd0);
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_LOAD) || (state_d == ST_FILL) ||
               (state_d == ST_READ) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
      load_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q        <= ST_IDLE;
         load_cnt_q     <= '0;
         wr_idx_q       <= '0;
         rd_idx_q       <= '0;
         wsum_q         <= '0;
         rsum_q         <= '0;
         err_count_q    <= '0;
         last_rd_data_q <= '0;
         pass_q         <= 1'b0;
         timeout_q      <= 1'b0;
         rd_pend_q      <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         load_q         <= 1'b0;
`ifdef SDRAM_SEQ_ROM_EN
         rom_addr_q     <= '0;
         rom_vld_q      <= 1'b0;
`else
         wr_data_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         load_cnt_q     <= load_cnt_d;
         wr_idx_q       <= wr_idx_d;
         rd_idx_q       <= rd_idx_d;
         wsum_q         <= wsum_d;
         rsum_q         <= rsum_d;
         err_count_q    <= err_count_d;
         last_rd_data_q <= last_rd_data_d;
         pass_q         <= pass_d;
         timeout_q      <= timeout_d;
         rd_pend_q      <= rd_pend_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         load_q         <= load_d;
`ifdef SDRAM_SEQ_ROM_EN
         rom_addr_q     <= rom_addr_d;
         rom_vld_q      <= rom_vld_d;
`else
         wr_data_q      <= wr_data_d;
`endif
      end
   end

   sdram_seq_timeout #(
      .WIDTH (CNT_W)
   ) u_timeout (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .clr      (to_clr),
      .load     (to_load),
      .load_val (CNT_W'(TIMEOUT)),
      .dec      (to_dec),
      .tc       (to_tc)
   );

   assign wr_data      = wr_word;
   assign wr_load      = load_q;
   assign rd_load      = load_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign timeout      = timeout_q;
   assign err_count    = err_count_q;
   assign last_rd_data = last_rd_data_q;

endmodule

// File: tb/tb_sdram_test_seq.sv
// Directed bench for sdram_test_seq with a loopback FIFO model (10-cycle latency) and pattern ROM model.
module tb_sdram_test_seq;

   localparam int DSIZE     = 16;
   localparam int NUM_WORDS = 16;
   localparam int TIMEOUT   = 64;
   localparam int LAT       = 10;

   logic             sys_clk   = 1'b0;
   logic             sys_rst_n = 1'b0;
   logic             start     = 1'b0;
   logic             wr_full   = 1'b0;
   logic             rd_empty  = 1'b1;
   logic [DSIZE-1:0] rom_q     = '0;
   logic [DSIZE-1:0] rd_data   = '0;
   logic [15:0]      rom_addr;
   logic [DSIZE-1:0] wr_data;
   logic             wr_en, wr_load, rd_load, rd_en, busy, done, pass, timeout;
   logic [15:0]      err_count;
   logic [DSIZE-1:0] last_rd_data;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [DSIZE-1:0] d;
      int               rdy;
   } ent_t;
   ent_t fifo_q[$];

   int          cyc            = 0;
   int          wr_cnt         = 0;
   int          rd_cnt         = 0;
   int          rd_limit       = 1000;
   int          corrupt_idx    = -1;
   int          seq_err        = 0;
   int          stall_viol     = 0;
   int          load_cycles    = 0;
   int          first_load_cyc = -1;
   int          first_wr_cyc   = -1;
   int          last_rd_cyc    = -1;
   logic [31:0] wsum_m         = '0;

   always #5 sys_clk = ~sys_clk;

   sdram_test_seq #(
      .DSIZE        (DSIZE),
      .NUM_WORDS    (NUM_WORDS),
      .PATTERN_SEED (16'hA5A5),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .start        (start),
      .rom_addr     (rom_addr),
      .rom_q        (rom_q),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .wr_full      (wr_full),
      .wr_load      (wr_load),
      .rd_load      (rd_load),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_empty     (rd_empty),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .timeout      (timeout),
      .err_count    (err_count),
      .last_rd_data (last_rd_data)
   );

   function automatic logic [DSIZE-1:0] exp_word(input int i);
`ifdef SDRAM_SEQ_ROM_EN
      return DSIZE'(i * 3);
`else
      logic [DSIZE-1:0] v;
      v = DSIZE'(i);
      return v ^ 16'hA5A5;
`endif
   endfunction

   // Controller stand-in: write FIFO looped back to the read FIFO, plus a synchronous ROM.
   always @(posedge sys_clk) begin : model
      ent_t             e;
      logic [DSIZE-1:0] d;
      cyc++;
      if (wr_load) begin
         if (first_load_cyc < 0) first_load_cyc = cyc;
         load_cycles++;
         fifo_q.delete();
         wr_cnt = 0;
         rd_cnt = 0;
         wsum_m = '0;
      end
      if (wr_en) begin
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         if (wr_full) stall_viol++;
         if (wr_data !== exp_word(wr_cnt)) seq_err++;
         wsum_m = wsum_m + 32'(wr_data);
         e.d    = wr_data;
         e.rdy  = cyc + LAT;
         fifo_q.push_back(e);
         wr_cnt++;
      end
      if (rd_en && (fifo_q.size() > 0)) begin
         e = fifo_q.pop_front();
         d = e.d;
         if (rd_cnt == corrupt_idx) d[0] = ~d[0];
         rd_data <= d;
         rd_cnt++;
         last_rd_cyc = cyc;
      end
      rom_q    <= DSIZE'(32'(rom_addr) * 3);
      rd_empty <= !((fifo_q.size() > 0) && (fifo_q[0].rdy <= cyc + 1) && (rd_cnt < rd_limit));
   end

   task automatic clear_mon();
      first_load_cyc = -1;
      first_wr_cyc   = -1;
      load_cycles    = 0;
      seq_err        = 0;
      stall_viol     = 0;
   endtask

   task automatic pulse_start();
      @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge sys_clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_chk++;
      if ({busy, done, pass, timeout, wr_en, rd_en, wr_load, rd_load} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {busy, done, pass, timeout, wr_en, rd_en, wr_load, rd_load});
      end
      n_chk++;
      if (rom_addr !== 16'h0000) begin
         n_fail++; $display("FAIL reset_rom_addr: got %h expected 0000", rom_addr);
      end
      n_chk++;
      if (wr_data !== 16'h0000) begin
         n_fail++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data);
      end
      n_chk++;
      if (err_count !== 16'h0000) begin
         n_fail++; $display("FAIL reset_err_count: got %h expected 0000", err_count);
      end
      n_chk++;
      if (last_rd_data !== 16'h0000) begin
         n_fail++; $display("FAIL reset_last_rd: got %h expected 0000", last_rd_data);
      end
   endtask

   task automatic test_loopback();
      bit ok;
      clear_mon();
      pulse_start();
      n_chk++;
      if ({busy, wr_load, rd_load} !== 3'b111) begin
         n_fail++; $display("FAIL loop_load_entry: got %b expected 111", {busy, wr_load, rd_load});
      end
      // start while busy must not restart the pass
      repeat (4) @(negedge sys_clk);
      start = 1'b1;
      repeat (2) @(negedge sys_clk);
      start = 1'b0;
      wait_done(500, ok);
      n_chk++;
      if (!ok) begin
         n_fail++; $display("FAIL loop_done_wait: got done=0 expected done=1");
      end
      n_chk++;
      if ({pass, timeout, busy} !== 3'b100) begin
         n_fail++; $display("FAIL loop_flags: got pass/timeout/busy=%b expected 100", {pass, timeout, busy});
      end
      n_chk++;
      if (err_count !== 16'd0) begin
         n_fail++; $display("FAIL loop_err_count: got %0d expected 0", err_count);
      end
      n_chk++;
`ifdef SDRAM_SEQ_ROM_EN
      if (last_rd_data !== 16'd45) begin
         n_fail++; $display("FAIL loop_last_rd: got %h expected 002d", last_rd_data);
      end
`else
      if (last_rd_data !== 16'hA5AA) begin
         n_fail++; $display("FAIL loop_last_rd: got %h expected a5aa", last_rd_data);
      end
`endif
      n_chk++;
      if ((wr_cnt !== 16) || (rd_cnt !== 16)) begin
         n_fail++; $display("FAIL loop_counts: got wr=%0d rd=%0d expected 16/16", wr_cnt, rd_cnt);
      end
      n_chk++;
      if (seq_err !== 0) begin
         n_fail++; $display("FAIL loop_wr_seq: got %0d bad words expected 0", seq_err);
      end
      n_chk++;
      if (load_cycles !== 2) begin
         n_fail++; $display("FAIL loop_load_width: got %0d cycles expected 2", load_cycles);
      end
      n_chk++;
`ifdef SDRAM_SEQ_ROM_EN
      if (first_wr_cyc - first_load_cyc !== 3) begin
         n_fail++; $display("FAIL loop_first_wr: got offset %0d expected 3", first_wr_cyc - first_load_cyc);
      end
      n_chk++;
      if (wsum_m !== 32'd360) begin
         n_fail++; $display("FAIL loop_wsum: got %0d expected 360", wsum_m);
      end
`else
      if (first_wr_cyc - first_load_cyc !== 2) begin
         n_fail++; $display("FAIL loop_first_wr: got offset %0d expected 2", first_wr_cyc - first_load_cyc);
      end
`endif
      repeat (5) @(negedge sys_clk);
      n_chk++;
      if ({done, pass} !== 2'b11) begin
         n_fail++; $display("FAIL loop_hold: got done/pass=%b expected 11", {done, pass});
      end
   endtask

   task automatic test_corrupt();
      bit ok;
      corrupt_idx = 3;
      clear_mon();
      pulse_start();
      wait_done(500, ok);
      corrupt_idx = -1;
      n_chk++;
      if (!ok) begin
         n_fail++; $display("FAIL corrupt_done_wait: got done=0 expected done=1");
      end
      n_chk++;
      if (pass !== 1'b0) begin
         n_fail++; $display("FAIL corrupt_pass: got %b expected 0", pass);
      end
      n_chk++;
`ifdef SDRAM_SEQ_ROM_EN
      if (err_count !== 16'd0) begin
         n_fail++; $display("FAIL corrupt_err_count: got %0d expected 0", err_count);
      end
`else
      if (err_count !== 16'd1) begin
         n_fail++; $display("FAIL corrupt_err_count: got %0d expected 1", err_count);
      end
`endif
   endtask

   task automatic test_stall();
      bit ok;
      int wr_before;
      int wr_seen;
      clear_mon();
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (wr_cnt >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!ok) begin
         n_fail++; $display("FAIL stall_reach_fill: got wr_cnt=%0d expected >=5", wr_cnt);
      end
      wr_full   = 1'b1;
      wr_before = wr_cnt;
      wr_seen   = 0;
      repeat (20) begin
         @(negedge sys_clk);
         if (wr_en) wr_seen++;
      end
      wr_full = 1'b0;
      n_chk++;
      if ((wr_seen !== 0) || (wr_cnt !== wr_before)) begin
         n_fail++;
         $display("FAIL stall_hold: got wr_en=%0d new words=%0d expected 0/0", wr_seen, wr_cnt - wr_before);
      end
      wait_done(600, ok);
      n_chk++;
      if (!ok) begin
         n_fail++; $display("FAIL stall_done_wait: got done=0 expected done=1");
      end
      n_chk++;
      if ((wr_cnt !== 16) || (stall_viol !== 0) || (seq_err !== 0)) begin
         n_fail++;
         $display("FAIL stall_writes: got wr=%0d viol=%0d seq=%0d expected 16/0/0", wr_cnt, stall_viol, seq_err);
      end
      n_chk++;
      if (pass !== 1'b1) begin
         n_fail++; $display("FAIL stall_pass: got %b expected 1", pass);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int lag;
      rd_limit = 12;
      clear_mon();
      pulse_start();
      wait_done(800, ok);
      rd_limit = 1000;
      lag = cyc - last_rd_cyc;
      n_chk++;
      if (!ok) begin
         n_fail++; $display("FAIL to_done_wait: got done=0 expected done=1");
      end
      n_chk++;
      if ({timeout, pass} !== 2'b10) begin
         n_fail++; $display("FAIL to_flags: got timeout/pass=%b expected 10", {timeout, pass});
      end
      n_chk++;
      if (rd_cnt !== 12) begin
         n_fail++; $display("FAIL to_rd_count: got %0d expected 12", rd_cnt);
      end
      n_chk++;
      if (last_rd_data !== exp_word(11)) begin
         n_fail++; $display("FAIL to_last_rd: got %h expected %h", last_rd_data, exp_word(11));
      end
      n_chk++;
      if ((lag < TIMEOUT) || (lag > TIMEOUT + 8)) begin
         n_fail++; $display("FAIL to_latency: got %0d cycles expected %0d..%0d", lag, TIMEOUT, TIMEOUT + 8);
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      clear_mon();
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge sys_clk);
         if (rd_cnt >= 4) begin
            ok = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!ok) begin
         n_fail++; $display("FAIL rst_reach_read: got rd_cnt=%0d expected >=4", rd_cnt);
      end
      sys_rst_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, done, pass, timeout, wr_en, rd_en, wr_load, rd_load} !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mid_ctrl: got %b expected 00000000",
                  {busy, done, pass, timeout, wr_en, rd_en, wr_load, rd_load});
      end
      n_chk++;
      if ({rom_addr, wr_data, err_count, last_rd_data} !== 64'h0) begin
         n_fail++;
         $display("FAIL rst_mid_data: got %h %h %h %h expected all 0", rom_addr, wr_data, err_count, last_rd_data);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      clear_mon();
      pulse_start();
      wait_done(500, ok);
      n_chk++;
      if (!ok || (pass !== 1'b1) || (rd_cnt !== 16)) begin
         n_fail++; $display("FAIL rst_rerun: got done=%b pass=%b rd=%0d expected 1/1/16", done, pass, rd_cnt);
      end
   endtask

   initial begin
      repeat (3) @(negedge sys_clk);
      test_reset();
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      test_loopback();
      test_corrupt();
      test_stall();
      test_timeout();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
